// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    // Clocks per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// Free-running divider producing a one-clk os_tick every DIV clocks.
module uart_os_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    output logic os_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign os_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, framing-error
// detection and break hold-off.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);

    logic       os_tick;
    logic       rx_m, rx_s;
    rx_state_t  state, state_n;
    logic [3:0] tick_cnt, tick_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shift, shift_n;
    logic [7:0] data_n;
    logic       dv_n, fe_n;

    uart_os_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .os_tick (os_tick)
    );

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            data          <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_n;
            bit_cnt       <= bit_n;
            shift         <= shift_n;
            data          <= data_n;
            data_valid    <= dv_n;
            framing_error <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = data;
        dv_n    = 1'b0;
        fe_n    = 1'b0;
        if (os_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        tick_n  = '0;
                    end
                end
                START: begin
                    // Half a bit in: confirm the start bit is still low.
                    if (tick_cnt == 4'd7) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_n = tick_cnt + 4'd1;
                    end
                end
                DATA: begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shift_n = {rx_s, shift[7:1]};
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state_n = STOP;
                            tick_n  = '0;
                        end
                    end
                end
                STOP: begin
                    tick_n = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        if (rx_s) begin
                            data_n  = shift;
                            dv_n    = 1'b1;
                            state_n = IDLE;
                        end else begin
                            fe_n    = 1'b1;
                            state_n = BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line returns high so a held-low line
                    // does not spawn a stream of bogus frames.
                    if (rx_s)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: scoreboard of expected strobes vs observed strobes.
module tb_uart_rx;

    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = 32;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] data;
    logic       dv, fe, busy;

    int n_cmp    = 0;
    int n_bad    = 0;
    int both_cnt = 0;
    int obs_rd   = 0;

    // {is_framing_error, byte}
    logic [8:0] obs_q[$];
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .rx_in         (rx_in),
        .data          (data),
        .data_valid    (dv),
        .framing_error (fe),
        .busy          (busy)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv) obs_q.push_back({1'b0, data});
            if (fe) obs_q.push_back({1'b1, 8'h00});
            if (dv && fe) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int cpb);
        rx_in = v;
        tick(cpb);
    endtask

    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) drive_bit(f[i], cpb);
        rx_in = 1'b1;
    endtask

    task automatic drain(input string tag);
        logic [8:0] e;
        check({tag, "_count"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                check({tag, "_strobe"}, 32'(obs_q[obs_rd]), 32'(e));
                obs_rd++;
            end
        end
        obs_rd = obs_q.size();
    endtask

    initial begin
        logic [7:0] b;
        logic [9:0] f;

        // Reset state
        tick(4);
        check("rst_data", 32'(data), 32'h00);
        check("rst_dv", 32'(dv), 32'h0);
        check("rst_fe", 32'(fe), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick(40);

        // Nominal frame, with a mid-frame busy check
        exp_q.push_back({1'b0, 8'hA5});
        f = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive_bit(f[i], BIT);
            if (i == 4) check("a5_busy_mid", 32'(busy), 32'h1);
        end
        rx_in = 1'b1;
        tick(2 * BIT);
        drain("a5");
        check("a5_data", 32'(data), 32'hA5);
        check("a5_busy_after", 32'(busy), 32'h0);

        // Short glitch is rejected at the start-bit midpoint
        rx_in = 1'b0;
        tick(6);
        rx_in = 1'b1;
        tick(40);
        drain("glitch");
        check("glitch_busy", 32'(busy), 32'h0);
        check("glitch_data", 32'(data), 32'hA5);

        // Framing error followed by a held-low break, then a clean frame
        exp_q.push_back({1'b1, 8'h00});
        send_frame(8'h3C, BIT, 1'b0);
        rx_in = 1'b0;
        tick(2 * BIT);
        check("break_busy", 32'(busy), 32'h1);
        tick(3 * BIT);
        rx_in = 1'b1;
        tick(2 * BIT);
        check("break_exit_busy", 32'(busy), 32'h0);
        drain("break");
        check("break_data_kept", 32'(data), 32'hA5);
        exp_q.push_back({1'b0, 8'h81});
        send_frame(8'h81, BIT, 1'b1);
        tick(2 * BIT);
        drain("after_break");
        check("after_break_data", 32'(data), 32'h81);

        // Back-to-back frames with no idle gap
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'h55});
        send_frame(8'h00, BIT, 1'b1);
        send_frame(8'hFF, BIT, 1'b1);
        send_frame(8'h55, BIT, 1'b1);
        tick(2 * BIT);
        drain("b2b");
        check("b2b_data", 32'(data), 32'h55);

        // Baud skew, fast then slow
        exp_q.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 30, 1'b1);
        tick(2 * BIT);
        drain("fast");
        check("fast_data", 32'(data), 32'hC3);
        exp_q.push_back({1'b0, 8'hC3});
        send_frame(8'hC3, 34, 1'b1);
        tick(2 * BIT);
        drain("slow");
        check("slow_data", 32'(data), 32'hC3);

        // Reset in the middle of bit 4 aborts the frame
        b = 8'h7E;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(b[i], BIT);
        drive_bit(b[4], BIT / 2);
        rst_n = 1'b0;
        tick(3);
        check("mid_rst_data", 32'(data), 32'h00);
        check("mid_rst_dv", 32'(dv), 32'h0);
        check("mid_rst_fe", 32'(fe), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        rx_in = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(12 * BIT);
        drain("aborted");
        check("aborted_data", 32'(data), 32'h00);
        exp_q.push_back({1'b0, 8'h7E});
        send_frame(8'h7E, BIT, 1'b1);
        tick(2 * BIT);
        drain("post_rst");
        check("post_rst_data", 32'(data), 32'h7E);

        check("no_dual_strobe", 32'(both_cnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart to the team's UART transmitter.
- Receives 8N1 frames (1 start, 8 data LSB-first, 1 stop) on an asynchronous serial line using 16x oversampling and mid-bit sampling.
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Contains its own oversample tick generator, so it instantiates standalone beside the transmitter in a UART top.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 9600: line bit rate in bits/s.
- OVERSAMPLE, 16: samples per bit. Fixed at 16; other values are unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line, idle high, asynchronous to clk.
- data  output  8  last correctly framed byte.
- data_valid  output  1  one-clk pulse when data updates.
- framing_error  output  1  one-clk pulse when the stop bit is sampled low.
- busy  output  1  high while in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - data=8'h00, data_valid=0, framing_error=0, busy=0.
  - FSM=IDLE, synchronizer flops=1, all counters=0.
- Reset mid-frame aborts the frame with no strobe.
- Synchronizer: 2-flop synchronizer on rx_in. All decisions use the synchronized value rx_s (2-clk latency).
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer truncation; DIV>=1 required.
  - Free-running counter 0..DIV-1.
  - os_tick is high for one clk when the counter equals DIV-1.
- FSM, evaluated only on os_tick cycles; tick_cnt is 4 bits:
  - IDLE: rx_s=0 -> START, tick_cnt=0.
  - START: increment tick_cnt. On tick_cnt==7 (mid start bit):
    - rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0.
    - rx_s=1 -> IDLE. False start (glitch); no strobe.
  - DATA: increment tick_cnt. On tick_cnt==15:
    - Shift rx_s into shift[7] with right shift, so the byte is assembled LSB-first.
    - bit_cnt++.
    - After the 8th bit -> STOP, tick_cnt=0.
  - STOP: on tick_cnt==15, sample rx_s:
    - rx_s=1: data<=shift, data_valid=1 for that one clk -> IDLE.
    - rx_s=0: framing_error=1 for that one clk; data unchanged -> BREAK.
  - BREAK: stay until rx_s=1 on an os_tick -> IDLE. This prevents a held-low line (break) from retriggering frames.
- Strobe timing:
  - data_valid and framing_error are registered.
  - They assert in the clk cycle after the os_tick on which the stop sample is taken.
  - They deassert the following clk.
  - They are never both high.
- data holds its value until the next valid frame.
- busy=0 only in IDLE. It is high in START/DATA/STOP/BREAK.
- Nominal frame latency, falling edge of start bit to data_valid: ~9.5 bit times + 2 clk synchronizer + up to 1 DIV of tick phase.
- Back-to-back frames: a start edge seen on the first os_tick after returning to IDLE must be accepted. No idle gap is required beyond the stop bit mid-point.

Decomposition:
- Shared package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}.
  - Constants DATA_BITS=8 and OVERSAMPLE=16.
  - Function computing DIV from CLK_FREQ/BAUD.
- One natural sub-module: uart_os_tick_gen (parameterised DIV, ports clk/reset/os_tick).
- Synchronizer and FSM stay in uart_rx.

Test Plan:
All scenarios use CLK_FREQ=3_200_000 and BAUD=100_000, giving DIV=2 and 32 clk per bit.
- Valid frame 8'hA5 driven at exactly 32 clk/bit -> one data_valid pulse, data=8'hA5, framing_error=0, busy falls after the pulse.
- Glitch: rx_in low for 6 clk (<8 ticks), then high -> no data_valid, no framing_error, FSM back in IDLE, data unchanged.
- Frame 8'h3C with stop bit driven low, line then held low for 5 bit times, then high, then valid frame 8'h81 -> exactly one framing_error pulse, no retrigger during the break, then data_valid with data=8'h81.
- Back-to-back bytes 8'h00, 8'hFF, 8'h55 with no idle between stop and next start -> three data_valid pulses in order with matching data.
- Baud skew: frame 8'hC3 at 30 and at 34 clk/bit (±6%) -> received correctly both times.
- Assert reset (low) during bit 4 of a frame, release, send 8'h7E -> outputs at reset values during reset, no strobe for the aborted frame, then data=8'h7E.
